two_one_arbiter: RTL and testbench

TWO_ONE_ARBITER -- requirements
Module: two_one_arbiter

---
 rtl/two_one_arbiter.sv | 106 ++++++++++
 tb/tb_two_one_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/two_one_arbiter.sv
// Two-source round-robin arbiter feeding a one-word output register.
// Grants are combinational; the selected word lands one cycle later.
module two_one_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             out_ready,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       cnt_a,
  output logic [7:0]       cnt_b
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_data;
  logic             r_sel;
  logic             r_last_b;
  logic [7:0]       r_cnt_a;
  logic [7:0]       r_cnt_b;

  logic w_accept;
  logic w_gnt_a;
  logic w_gnt_b;
  logic w_gnt;

  assign w_accept = (r_state == EMPTY) | out_ready;
  assign w_gnt    = w_gnt_a | w_gnt_b;

  // rst_n gates the grants so nothing leaks out while reset is held
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (rst_n && w_accept) begin
      unique case (1'b1)
        (req_a & req_b): begin
          w_gnt_a = r_last_b;
          w_gnt_b = ~r_last_b;
        end
        (req_a & ~req_b): w_gnt_a = 1'b1;
        (~req_a & req_b): w_gnt_b = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_gnt) begin
      w_state_nx = FULL;
    end else if (out_ready) begin
      w_state_nx = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_sel    <= 1'b0;
      r_last_b <= 1'b1;
      r_cnt_a  <= 8'd0;
      r_cnt_b  <= 8'd0;
    end else if (w_gnt) begin
      r_data   <= w_gnt_b ? data_b : data_a;
      r_sel    <= w_gnt_b;
      r_last_b <= w_gnt_b;
      if (w_gnt_b) begin
        r_cnt_b <= r_cnt_b + 8'd1;
      end else begin
        r_cnt_a <= r_cnt_a + 8'd1;
      end
    end
  end

  assign gnt_a     = w_gnt_a;
  assign gnt_b     = w_gnt_b;
  assign en        = w_gnt;
  assign sel       = w_gnt ? w_gnt_b : r_sel;
  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign cnt_a     = r_cnt_a;
  assign cnt_b     = r_cnt_b;

endmodule

// File: tb/tb_two_one_arbiter.sv
// Bench for two_one_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the arbiter.
module tb_two_one_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic [7:0] data_a = 8'd0;
  logic [7:0] data_b = 8'd0;
  logic       out_ready = 1'b0;
  logic       gnt_a, gnt_b, sel, en, out_valid;
  logic [7:0] out_data, cnt_a, cnt_b;

  int total = 0;
  int bad = 0;

  // model: what the downstream sees, plus who was granted last
  bit       m_valid;
  bit [7:0] m_data;
  bit       m_last_b;
  bit       m_sel;
  int       m_ca;
  int       m_cb;

  always #5 clk = ~clk;

  two_one_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .out_ready(out_ready),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .sel(sel), .en(en),
    .out_valid(out_valid), .out_data(out_data),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  task automatic mdl_reset();
    m_valid = 0; m_data = 0; m_last_b = 1;
    m_sel = 0; m_ca = 0; m_cb = 0;
  endtask

  task automatic mdl_comb(output bit ga, output bit gb, output bit es);
    bit acc;
    acc = !m_valid || out_ready;
    ga = 0; gb = 0;
    if (acc && req_a && req_b) begin
      // whoever was not served last wins the tie
      ga = m_last_b;
      gb = !m_last_b;
    end else if (acc) begin
      ga = req_a;
      gb = req_b;
    end
    es = (ga || gb) ? gb : m_sel;
  endtask

  task automatic mdl_clock(input bit ga, input bit gb);
    if (ga || gb) begin
      m_data = gb ? data_b : data_a;
      m_valid = 1;
      m_sel = gb;
      m_last_b = gb;
      if (ga) m_ca = (m_ca + 1) % 256;
      else m_cb = (m_cb + 1) % 256;
    end else if (out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #2;
    mdl_reset();
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; req_a = 1; req_b = 1; out_ready = 1;
    data_a = 8'h11; data_b = 8'h22;
    #3;
    mdl_reset();
    total++;
    if ({gnt_a, gnt_b, en, sel, out_valid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=00000",
               {gnt_a, gnt_b, en, sel, out_valid});
    end
    total++;
    if ({out_data, cnt_a, cnt_b} !== 24'd0) begin
      bad++;
      $display("FAIL reset_regs got=%h/%h/%h exp=0/0/0",
               out_data, cnt_a, cnt_b);
    end
    @(negedge clk);
    req_a = 0; req_b = 0;
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ga, gb, es;
    req_a = 1; req_b = 0; data_a = 8'h3C; out_ready = 1;
    #1;
    mdl_comb(ga, gb, es);
    total++;
    if ({gnt_a, gnt_b, sel, en} !== 4'b1001) begin
      bad++;
      $display("FAIL single_c0 got=%b exp=1001",
               {gnt_a, gnt_b, sel, en});
    end
    @(posedge clk);
    mdl_clock(ga, gb);
    #1;
    req_a = 0;
    total++;
    if ({out_valid, out_data, cnt_a} !== {1'b1, 8'h3C, 8'd1}) begin
      bad++;
      $display("FAIL single_c1 got=%b/%h/%0d exp=1/3c/1",
               out_valid, out_data, cnt_a);
    end
    @(negedge clk);
  endtask

  task automatic test_alternate();
    bit ga, gb, es;
    logic [7:0] exp_d [4];
    exp_d = '{8'hAA, 8'h55, 8'hAA, 8'h55};
    do_reset();
    req_a = 1; req_b = 1; data_a = 8'hAA; data_b = 8'h55;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      mdl_comb(ga, gb, es);
      total++;
      if (sel !== i[0] || en !== 1'b1) begin
        bad++;
        $display("FAIL alt_sel%0d got=%b/%b exp=%b/1",
                 i, sel, en, i[0]);
      end
      @(posedge clk);
      mdl_clock(ga, gb);
      #1;
      total++;
      if (out_data !== exp_d[i] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL alt_data%0d got=%h exp=%h",
                 i, out_data, exp_d[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    bit ga, gb, es;
    logic [7:0] held;
    held = out_data;
    req_a = 1; req_b = 1; out_ready = 0;
    data_a = 8'h01; data_b = 8'h02;
    for (int i = 0; i < 3; i++) begin
      #1;
      mdl_comb(ga, gb, es);
      total++;
      if (gnt_a || gnt_b || en) begin
        bad++;
        $display("FAIL stall_gnt%0d got=%b%b exp=00",
                 i, gnt_a, gnt_b);
      end
      @(posedge clk);
      mdl_clock(ga, gb);
      #1;
      total++;
      if (out_data !== held || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold%0d got=%h exp=%h",
                 i, out_data, held);
      end
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    mdl_comb(ga, gb, es);
    total++;
    if ((gnt_a ^ gnt_b) !== 1'b1 || gnt_a !== ga) begin
      bad++;
      $display("FAIL stall_release got=%b%b exp=%b%b",
               gnt_a, gnt_b, ga, gb);
    end
    @(posedge clk);
    mdl_clock(ga, gb);
    #1;
    total++;
    if (out_data !== m_data) begin
      bad++;
      $display("FAIL stall_word got=%h exp=%h", out_data, m_data);
    end
    @(negedge clk);
  endtask

  task automatic test_drain();
    bit ga, gb, es;
    req_a = 0; req_b = 1; data_b = 8'h77; out_ready = 1;
    #1;
    mdl_comb(ga, gb, es);
    @(posedge clk);
    mdl_clock(ga, gb);
    @(negedge clk);
    req_b = 0;
    #1;
    mdl_comb(ga, gb, es);
    total++;
    if (en !== 1'b0 || sel !== 1'b1 || sel !== es) begin
      bad++;
      $display("FAIL drain_sel got=%b/%b exp=0/1", en, sel);
    end
    @(posedge clk);
    mdl_clock(ga, gb);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h77) begin
      bad++;
      $display("FAIL drain_valid got=%b/%h exp=0/77",
               out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bit ga, gb, es;
    req_a = 0; req_b = 1; data_b = 8'h99; out_ready = 0;
    #1;
    mdl_comb(ga, gb, es);
    @(posedge clk);
    mdl_clock(ga, gb);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    mdl_reset();
    total++;
    if ({out_valid, out_data, cnt_a, cnt_b, gnt_b} !== 26'd0) begin
      bad++;
      $display("FAIL areset got=%b/%h/%h/%h exp=0/0/0/0",
               out_valid, out_data, cnt_a, cnt_b);
    end
    rst_n = 1;
    req_a = 1; req_b = 1; out_ready = 1;
    #1;
    mdl_comb(ga, gb, es);
    total++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      bad++;
      $display("FAIL areset_tie got=%b%b exp=10", gnt_a, gnt_b);
    end
    @(posedge clk);
    mdl_clock(ga, gb);
    @(negedge clk);
    req_a = 0; req_b = 0;
  endtask

  task automatic test_wrap();
    bit ga, gb, es;
    do_reset();
    req_a = 1; req_b = 0; out_ready = 1;
    for (int i = 0; i < 256; i++) begin
      data_a = 8'($urandom);
      #1;
      mdl_comb(ga, gb, es);
      @(posedge clk);
      mdl_clock(ga, gb);
      #1;
      if (i == 254) begin
        total++;
        if (cnt_a !== 8'd255) begin
          bad++;
          $display("FAIL wrap_255 got=%0d exp=255", cnt_a);
        end
      end
      @(negedge clk);
    end
    total++;
    if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
      bad++;
      $display("FAIL wrap_zero got=%0d/%0d exp=0/0", cnt_a, cnt_b);
    end
    req_a = 0;
  endtask

  task automatic test_random();
    bit ga, gb, es;
    for (int i = 0; i < 400; i++) begin
      req_a = 1'($urandom);
      req_b = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      data_a = 8'($urandom);
      data_b = 8'($urandom);
      #1;
      mdl_comb(ga, gb, es);
      total++;
      if ({gnt_a, gnt_b, sel, en} !== {ga, gb, es, ga | gb}) begin
        bad++;
        $display("FAIL rand_comb%0d got=%b exp=%b", i,
                 {gnt_a, gnt_b, sel, en}, {ga, gb, es, ga | gb});
      end
      @(posedge clk);
      mdl_clock(ga, gb);
      #1;
      total++;
      if (out_valid !== m_valid || out_data !== m_data ||
          cnt_a !== 8'(m_ca) || cnt_b !== 8'(m_cb)) begin
        bad++;
        $display("FAIL rand_regs%0d got=%b/%h/%0d/%0d exp=%b/%h/%0d/%0d",
                 i, out_valid, out_data, cnt_a, cnt_b,
                 m_valid, m_data, m_ca, m_cb);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_drain();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
